// File: rtl/ram_req_sequencer_if.sv
// ram_req_sequencer_if: host and memory signal bundle for ram_req_sequencer
//   host_*  : cartridge-side RAM host (address, active-low strobes, write data, refresh strobe, read data)
//   mem_*   : memory command channel (req/ack, read data return, refresh req/ack)
//   master  : the environment side (drives host pins and memory responses)
//   slave   : the sequencer side
interface ram_req_sequencer_if #(
    parameter int ADDR_WIDTH = 22
);
    logic [ADDR_WIDTH-1:0] host_addr;
    logic                  host_oe_n;
    logic                  host_we_n;
    logic [15:0]           host_din;
    logic                  host_din_size;
    logic                  host_rfsh_n;
    logic [15:0]           host_dout;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0]           mem_wdata;
    logic [1:0]            mem_be;
    logic                  mem_ack;
    logic                  mem_rvalid;
    logic [15:0]           mem_rdata;
    logic                  mem_rfsh_req;
    logic                  mem_rfsh_ack;

    modport master (
        output host_addr, host_oe_n, host_we_n, host_din, host_din_size, host_rfsh_n,
        output mem_ack, mem_rvalid, mem_rdata, mem_rfsh_ack,
        input  host_dout, mem_req, mem_we, mem_addr, mem_wdata, mem_be, mem_rfsh_req
    );

    modport slave (
        input  host_addr, host_oe_n, host_we_n, host_din, host_din_size, host_rfsh_n,
        input  mem_ack, mem_rvalid, mem_rdata, mem_rfsh_ack,
        output host_dout, mem_req, mem_we, mem_addr, mem_wdata, mem_be, mem_rfsh_req
    );
endinterface

// File: rtl/ram_req_sequencer.sv
// ram_req_sequencer: turns MSX-style host RAM strobes into single memory commands plus refresh requests
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ram_req_sequencer_if.slave -- host strobes/address/data in, host_dout out,
//          mem_req/mem_we/mem_addr/mem_wdata/mem_be out with mem_ack, mem_rvalid/mem_rdata in,
//          mem_rfsh_req out with mem_rfsh_ack in
module ram_req_sequencer #(
    parameter int ADDR_WIDTH    = 22,
    parameter int RFSH_PEND_MAX = 3
) (
    input  logic               clk,
    input  logic               rst,
    ram_req_sequencer_if.slave bus
);
    localparam logic [2:0] PEND_MAX = 3'(RFSH_PEND_MAX);

    typedef enum logic [2:0] {IDLE, CMD, RDWAIT, HOLD, RFSH} state_t;

    state_t                state_q, state_d;
    logic                  oe_q, oe_p_q, we_q, we_p_q, rf_q, rf_p_q, size_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_p_q;
    logic [15:0]           din_q;
    logic                  pend_q, pend_we_q;
    logic [ADDR_WIDTH-1:0] pend_addr_q;
    logic [15:0]           pend_wdata_q;
    logic [1:0]            pend_be_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [15:0]           mem_wdata_q, dout_q;
    logic [1:0]            mem_be_q;
    logic [2:0]            cnt_q, cnt_d;
    logic                  wr_ev, rd_ev, acc_ev, rf_ev, rf_ack, start;
    logic [15:0]           cur_wdata;
    logic [1:0]            cur_be;

    // Edges come from two register stages so a pin edge reaches the FSM one cycle after it is registered.
    // A write edge wins over a simultaneous read edge.
    assign wr_ev     = we_p_q & ~we_q;
    assign rd_ev     = ~oe_q & (oe_p_q | (addr_q != addr_p_q));
    assign acc_ev    = wr_ev | rd_ev;
    assign rf_ev     = rf_p_q & ~rf_q;
    assign rf_ack    = (state_q == RFSH) && bus.mem_rfsh_ack;
    assign start     = ((state_q == IDLE) || (state_q == HOLD)) && (acc_ev || pend_q);
    assign cur_wdata = !wr_ev ? 16'h0000 : size_q ? din_q : {8'h00, din_q[7:0]};
    assign cur_be    = (wr_ev && !size_q) ? 2'b01 : 2'b11;
    assign cnt_d     = (rf_ev && !rf_ack && cnt_q != PEND_MAX) ? cnt_q + 3'd1 :
                       (rf_ack && !rf_ev) ? cnt_q - 3'd1 : cnt_q;

    always_ff @(posedge clk) begin
        state_q <= rst ? IDLE : state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? CMD : (cnt_q != 3'd0) ? RFSH : IDLE;
            CMD:     state_d = !bus.mem_ack ? CMD : mem_we_q ? HOLD : RDWAIT;
            RDWAIT:  state_d = bus.mem_rvalid ? HOLD : RDWAIT;
            HOLD:    state_d = start ? CMD : (oe_q && we_q) ? IDLE : HOLD;
            RFSH:    state_d = rf_ack ? IDLE : RFSH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req      = state_q == CMD;
        bus.mem_rfsh_req = state_q == RFSH;
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.host_dout = dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            {oe_q, oe_p_q, we_q, we_p_q, rf_q, rf_p_q} <= 6'b111111;
            size_q       <= 1'b0;
            addr_q       <= '0;
            addr_p_q     <= '0;
            din_q        <= '0;
            pend_q       <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_wdata_q <= '0;
            pend_be_q    <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            dout_q       <= '0;
            cnt_q        <= '0;
        end else begin
            oe_q     <= bus.host_oe_n;
            oe_p_q   <= oe_q;
            we_q     <= bus.host_we_n;
            we_p_q   <= we_q;
            rf_q     <= bus.host_rfsh_n;
            rf_p_q   <= rf_q;
            addr_q   <= bus.host_addr;
            addr_p_q <= addr_q;
            din_q    <= bus.host_din;
            size_q   <= bus.host_din_size;
            cnt_q    <= cnt_d;
            // A fresh edge beats whatever was pending; otherwise an edge seen while busy is parked.
            if (start) begin
                mem_we_q    <= acc_ev ? wr_ev : pend_we_q;
                mem_addr_q  <= acc_ev ? addr_q : pend_addr_q;
                mem_wdata_q <= acc_ev ? cur_wdata : pend_wdata_q;
                mem_be_q    <= acc_ev ? cur_be : pend_be_q;
                pend_q      <= 1'b0;
            end else if (acc_ev) begin
                pend_q       <= 1'b1;
                pend_we_q    <= wr_ev;
                pend_addr_q  <= addr_q;
                pend_wdata_q <= cur_wdata;
                pend_be_q    <= cur_be;
            end
            if (state_q == RDWAIT && bus.mem_rvalid)
                dout_q <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_ram_req_sequencer.sv
// tb_ram_req_sequencer: self-checking bench for ram_req_sequencer
module tb_ram_req_sequencer;
    localparam int AW = 22;

    typedef struct {
        bit            wr;
        bit            sz;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [15:0]   rdata;
        logic [1:0]    exp_be;
        logic [15:0]   exp_wdata;
        logic [15:0]   exp_dout;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_req_sequencer_if #(.ADDR_WIDTH(AW)) bus ();
    ram_req_sequencer #(.ADDR_WIDTH(AW), .RFSH_PEND_MAX(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0, passed = 0, cyc = 0;
    int ack_dly = 0, rv_dly = 1;
    bit rfsh_ack_en = 1'b1;
    int cmd_cnt = 0, rv_cnt_tot = 0, rf_hs = 0, unstable = 0, both_err = 0;
    int req_start_cyc = 0, rv_cyc = 0, rfsh_start_cyc = 0;
    logic          last_we = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [15:0]   last_wdata = '0;
    logic [1:0]    last_be = '0;
    logic [15:0]   resp_mem [int];
    logic [15:0]   ref_mem [int];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(input int a);
        return 16'(a * 40503) ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Memory model: acks after ack_dly cycles, returns read data rv_dly cycles after the ack.
    initial begin : responder
        int            wait_n, rv_left, ai;
        logic          prev_req, prev_rf;
        logic [15:0]   rv_data, old;
        logic [AW+18:0] snap;
        wait_n = 0; rv_left = 0; prev_req = 1'b0; prev_rf = 1'b0; rv_data = '0; snap = '0;
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.mem_rfsh_ack = 1'b0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rfsh_ack = 1'b0;
            if (bus.mem_req && bus.mem_rfsh_req) both_err++;
            if (rv_left > 0) begin
                rv_left--;
                if (rv_left == 0) begin
                    bus.mem_rvalid = 1'b1; bus.mem_rdata = rv_data; rv_cnt_tot++; rv_cyc = cyc;
                end
            end
            if (bus.mem_req) begin
                if (!prev_req) begin
                    snap = {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be};
                    req_start_cyc = cyc; wait_n = 0;
                end else if (snap != {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be}) unstable++;
                if (wait_n >= ack_dly) begin
                    bus.mem_ack = 1'b1; cmd_cnt++;
                    last_we = bus.mem_we; last_addr = bus.mem_addr; last_wdata = bus.mem_wdata; last_be = bus.mem_be;
                    ai = int'(bus.mem_addr);
                    old = resp_mem.exists(ai) ? resp_mem[ai] : init_val(ai);
                    if (bus.mem_we) begin
                        if (bus.mem_be[1]) old[15:8] = bus.mem_wdata[15:8];
                        if (bus.mem_be[0]) old[7:0] = bus.mem_wdata[7:0];
                        resp_mem[ai] = old;
                    end else begin
                        rv_left = rv_dly; rv_data = old;
                    end
                end
                wait_n++;
            end
            if (bus.mem_rfsh_req && !prev_rf) rfsh_start_cyc = cyc;
            if (bus.mem_rfsh_req && rfsh_ack_en) begin
                bus.mem_rfsh_ack = 1'b1; rf_hs++;
            end
            prev_req = bus.mem_req; prev_rf = bus.mem_rfsh_req;
        end
    end

    task automatic host_access(input bit wr, input bit sz, input logic [AW-1:0] a, input logic [15:0] d,
                               input bit rf, output int lat);
        int c0, r0, s_cyc, n;
        n = 0;
        @(negedge clk);
        c0 = cmd_cnt; r0 = rv_cnt_tot;
        bus.host_addr = a; bus.host_din = d; bus.host_din_size = sz;
        if (wr) bus.host_we_n = 1'b0; else bus.host_oe_n = 1'b0;
        if (rf) bus.host_rfsh_n = 1'b0;
        s_cyc = cyc;
        while ((cmd_cnt == c0 || (!wr && rv_cnt_tot == r0)) && n < 60) begin
            @(negedge clk);
            bus.host_rfsh_n = 1'b1;
            n++;
        end
        check("access_done", n < 60, 1);
        lat = req_start_cyc - s_cyc;
        @(negedge clk);
        bus.host_oe_n = 1'b1; bus.host_we_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vec [7];
        int          c0, h0, r0, lat, n, pulses;
        bit          wr, sz, rf;
        int          a;
        logic [15:0] d, old, ref_dout;
        vec[0] = '{0, 1, 22'h001234, 16'h0000, 16'hBEEF, 2'b11, 16'h0000, 16'hBEEF};
        vec[1] = '{1, 0, 22'h000100, 16'h1255, 16'h0000, 2'b01, 16'h0055, 16'hBEEF};
        vec[2] = '{1, 1, 22'h000200, 16'hA5C3, 16'h0000, 2'b11, 16'hA5C3, 16'hBEEF};
        vec[3] = '{0, 1, 22'h3FFFFF, 16'h0000, 16'h1234, 2'b11, 16'h0000, 16'h1234};
        vec[4] = '{0, 0, 22'h000000, 16'h0000, 16'h0000, 2'b11, 16'h0000, 16'h0000};
        vec[5] = '{1, 0, 22'h3FFFFF, 16'hFFFF, 16'h0000, 2'b01, 16'h00FF, 16'h0000};
        vec[6] = '{0, 1, 22'h155555, 16'h0000, 16'h5AA5, 2'b11, 16'h0000, 16'h5AA5};
        bus.host_addr = '0; bus.host_din = '0; bus.host_din_size = 1'b0;
        bus.host_oe_n = 1'b1; bus.host_we_n = 1'b1; bus.host_rfsh_n = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_dout", bus.host_dout, 0);
        check("rst_req", bus.mem_req, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_be", bus.mem_be, 0);
        check("rst_rfsh_req", bus.mem_rfsh_req, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // directed vectors: one host access each, fixed memory latency
        ack_dly = 3; rv_dly = 2;
        for (int i = 0; i < 7; i++) begin
            if (!vec[i].wr) resp_mem[int'(vec[i].addr)] = vec[i].rdata;
            c0 = cmd_cnt;
            host_access(vec[i].wr, vec[i].sz, vec[i].addr, vec[i].din, 1'b0, lat);
            check($sformatf("v%0d_cmds", i), cmd_cnt - c0, 1);
            check($sformatf("v%0d_we", i), last_we, vec[i].wr);
            check($sformatf("v%0d_be", i), last_be, vec[i].exp_be);
            check($sformatf("v%0d_addr", i), last_addr, vec[i].addr);
            if (vec[i].wr) check($sformatf("v%0d_wdata", i), last_wdata, vec[i].exp_wdata);
            check($sformatf("v%0d_dout", i), bus.host_dout, vec[i].exp_dout);
            check($sformatf("v%0d_latency", i), lat >= 2, 1);
        end

        // refresh saturation: five pulses with no ack, then three handshakes only
        rfsh_ack_en = 1'b0; h0 = rf_hs;
        repeat (5) begin
            @(negedge clk) bus.host_rfsh_n = 1'b0;
            @(negedge clk) bus.host_rfsh_n = 1'b1;
        end
        repeat (3) @(negedge clk);
        check("sat_req_held", bus.mem_rfsh_req, 1);
        check("sat_no_hs", rf_hs - h0, 0);
        rfsh_ack_en = 1'b1;
        repeat (20) @(negedge clk);
        check("sat_hs", rf_hs - h0, 3);
        check("sat_req_idle", bus.mem_rfsh_req, 0);

        // priority: refresh edge and read edge together, read goes first
        ack_dly = 1; rv_dly = 2; c0 = cmd_cnt; h0 = rf_hs;
        resp_mem[int'(22'h000777)] = 16'h4321;
        host_access(1'b0, 1'b1, 22'h000777, 16'h0000, 1'b1, lat);
        repeat (6) @(negedge clk);
        check("prio_cmds", cmd_cnt - c0, 1);
        check("prio_rfsh_hs", rf_hs - h0, 1);
        check("prio_rfsh_after_read", rfsh_start_cyc > rv_cyc, 1);
        check("prio_dout", bus.host_dout, 16'h4321);

        // collision: both strobes fall together, only the write goes out
        c0 = cmd_cnt;
        @(negedge clk);
        bus.host_addr = 22'h000321; bus.host_din = 16'hC0DE; bus.host_din_size = 1'b1;
        bus.host_oe_n = 1'b0; bus.host_we_n = 1'b0;
        repeat (10) @(negedge clk);
        check("coll_cmds", cmd_cnt - c0, 1);
        check("coll_we", last_we, 1);
        check("coll_wdata", last_wdata, 16'hC0DE);
        bus.host_oe_n = 1'b1; bus.host_we_n = 1'b1;
        repeat (6) @(negedge clk);
        check("coll_cmds_after", cmd_cnt - c0, 1);
        check("coll_dout", bus.host_dout, 16'h4321);

        // reset while a command waits for its ack: request drops, no ack afterwards
        ack_dly = 10; c0 = cmd_cnt; n = 0;
        @(negedge clk);
        bus.host_addr = 22'h000055; bus.host_oe_n = 1'b0;
        while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
        check("mid_req_seen", bus.mem_req, 1);
        rst = 1'b1; bus.host_oe_n = 1'b1;
        @(negedge clk);
        check("mid_req_dropped", bus.mem_req, 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_no_ack", cmd_cnt - c0, 0);

        // reset during RDWAIT: late read data must be ignored
        ack_dly = 0; rv_dly = 8; c0 = cmd_cnt; r0 = rv_cnt_tot; n = 0;
        resp_mem[int'(22'h0000AB)] = 16'h7777;
        @(negedge clk);
        bus.host_addr = 22'h0000AB; bus.host_oe_n = 1'b0;
        while (cmd_cnt == c0 && n < 30) begin @(negedge clk); n++; end
        check("rdw_acked", cmd_cnt - c0, 1);
        @(negedge clk);
        rst = 1'b1; bus.host_oe_n = 1'b1;
        @(negedge clk);
        rst = 1'b0; n = 0;
        while (rv_cnt_tot == r0 && n < 20) begin @(negedge clk); n++; end
        check("rdw_rvalid_sent", rv_cnt_tot - r0, 1);
        repeat (3) @(negedge clk);
        check("rdw_dout", bus.host_dout, 0);
        check("rdw_req", bus.mem_req, 0);
        check("rdw_rfsh_req", bus.mem_rfsh_req, 0);
        check("rdw_cmds", cmd_cnt - c0, 1);

        // random accesses against a word-addressed memory model, with refresh pulses mixed in
        resp_mem.delete(); ref_mem.delete();
        ref_dout = 16'h0000; pulses = 0; h0 = rf_hs;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1)); sz = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 15); d = 16'($urandom); rf = ($urandom_range(0, 2) == 0);
            ack_dly = $urandom_range(0, 3); rv_dly = $urandom_range(1, 3);
            c0 = cmd_cnt;
            host_access(wr, sz, AW'(a), d, rf, lat);
            old = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
            if (wr) ref_mem[a] = sz ? d : {old[15:8], d[7:0]};
            else ref_dout = old;
            if (rf) pulses++;
            check($sformatf("rnd%0d_cmds", i), cmd_cnt - c0, 1);
            check($sformatf("rnd%0d_dout", i), bus.host_dout, ref_dout);
        end
        repeat (10) @(negedge clk);
        check("rnd_rfsh_hs", rf_hs - h0, pulses);
        check("never_both_req", both_err, 0);
        check("cmd_stable", unstable, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
